// File: rtl/uart_prog_streamer.sv
// rtl/uart_prog_streamer.sv - streams program words from a read port as UART frames
//
// Fetches words from a word-addressed memory and sends each byte, most
// significant byte first, as a UART frame on tx. Streaming stops after an
// END_MARKER word or after MAX_WORDS words. The marker word is always
// transmitted before done is raised.
//
// Optional feature: define UART_PARITY_EN to add an even-parity bit after the
// data bits.
//
// Ports:
//   clk, resetn           clock and synchronous active-low reset
//   start                 level input; streaming proceeds only while it is high
//   mem_req, mem_addr     one-cycle read strobe and word address
//   mem_rdata, mem_valid  read data and its valid strobe
//   tx                    UART serial output, idle high
//   busy, done            streaming in progress / stream finished
//   word_count            words fully transmitted, marker excluded
module uart_prog_streamer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int WORD_BYTES = 4,
  parameter int ADDR_W = 12,
  parameter int MAX_WORDS = 4096,
  parameter logic [8*WORD_BYTES-1:0] END_MARKER = 'h0000_0FFF,
  parameter int STOP_BITS = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  output logic                    mem_req,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [8*WORD_BYTES-1:0] mem_rdata,
  input  logic                    mem_valid,
  output logic                    tx,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W:0]         word_count
);

  localparam int W = 8 * WORD_BYTES;
  localparam int CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
  localparam int BI_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0] WORD_LIMIT = (ADDR_W + 1)'(MAX_WORDS);
  localparam logic [BI_W-1:0] BYTE_TOP = BI_W'(WORD_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [BI_W-1:0]  byte_idx;
  logic [W-1:0]     word_q;
  logic             last_q;
  logic             abort_q;
  // One counter serves as both fetch address and transmitted-word count:
  // it advances exactly when a non-marker word has been fully sent. It is one
  // bit wider than the address so that MAX_WORDS == 2**ADDR_W is reachable.
  logic [ADDR_W:0]  word_idx;
  logic             tx_q, mem_req_q, busy_q, done_q;
  logic             tx_d, mem_req_d, busy_d, done_d;

  logic [W-1:0] shifted;
  logic [7:0]   cur_byte;
  logic         bit_end, stop_end, at_limit, abort_now;

  assign shifted   = word_q >> {byte_idx, 3'b000};
  assign cur_byte  = shifted[7:0];
  assign bit_end   = (clk_cnt == BIT_LAST);
  assign stop_end  = (clk_cnt == STOP_LAST);
  assign at_limit  = (word_idx == WORD_LIMIT);
  // A drop of start inside a frame is remembered until the stop bits finish.
  assign abort_now = abort_q || !start;

  assign tx         = tx_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = word_idx[ADDR_W-1:0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign word_count = word_idx;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_FETCH;
      S_FETCH: begin
        if (!start)        state_nx = S_IDLE;
        else if (at_limit) state_nx = S_START;
        else               state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (!start)         state_nx = S_IDLE;
        else if (mem_valid) state_nx = S_START;
      end
      S_START: if (bit_end) state_nx = S_DATA;
      S_DATA: begin
        if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
          state_nx = S_PARITY;
`else
          state_nx = S_STOP;
`endif
        end
      end
      S_PARITY: if (bit_end) state_nx = S_STOP;
      S_STOP: begin
        if (stop_end) begin
          if (abort_now)             state_nx = S_IDLE;
          else if (byte_idx != '0)   state_nx = S_START;
          else if (last_q)           state_nx = S_DONE;
          else                       state_nx = S_FETCH;
        end
      end
      S_DONE:  if (!start) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs. tx follows the
  // current state, so the line changes one cycle after a state change; busy
  // and done follow the next state so they line up with mem_req and DONE.
  always_comb begin
    tx_d = 1'b1;
    case (state)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = cur_byte[bit_idx];
      S_PARITY: tx_d = ^cur_byte;
      default:  tx_d = 1'b1;
    endcase
    mem_req_d = (state == S_FETCH) && start && !at_limit;
    busy_d    = (state != S_IDLE) && (state_nx != S_IDLE) && (state_nx != S_DONE);
    done_d    = (state_nx == S_DONE);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      clk_cnt   <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      word_q    <= '0;
      last_q    <= 1'b0;
      abort_q   <= 1'b0;
      word_idx  <= '0;
      tx_q      <= 1'b1;
      mem_req_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      tx_q      <= tx_d;
      mem_req_q <= mem_req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;

      case (state)
        S_START, S_DATA, S_PARITY: clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
        S_STOP:                    clk_cnt <= stop_end ? '0 : clk_cnt + 1'b1;
        default:                   clk_cnt <= '0;
      endcase

      // Wraps 7 -> 0 on its own at the end of the last data bit.
      if (state == S_DATA) begin
        if (bit_end) bit_idx <= bit_idx + 1'b1;
      end else begin
        bit_idx <= '0;
      end

      if (state == S_IDLE) abort_q <= 1'b0;
      else if (!start && (state == S_START || state == S_DATA ||
                          state == S_PARITY || state == S_STOP))
        abort_q <= 1'b1;

      case (state)
        S_IDLE: begin
          word_idx <= '0;
          last_q   <= 1'b0;
          byte_idx <= '0;
        end
        S_FETCH: begin
          if (at_limit) begin
            word_q   <= END_MARKER;
            last_q   <= 1'b1;
            byte_idx <= BYTE_TOP;
          end
        end
        S_WAIT: begin
          if (start && mem_valid) begin
            word_q   <= mem_rdata;
            last_q   <= (mem_rdata == END_MARKER);
            byte_idx <= BYTE_TOP;
          end
        end
        S_STOP: begin
          if (stop_end && !abort_now) begin
            if (byte_idx != '0) byte_idx <= byte_idx - 1'b1;
            else if (!last_q)   word_idx <= word_idx + 1'b1;
          end
        end
        S_DONE: if (!start) word_idx <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_prog_streamer.sv
// tb/tb_uart_prog_streamer.sv - directed bench for uart_prog_streamer
module tb_uart_prog_streamer;

  localparam int CPB = 4;
`ifdef UART_PARITY_EN
  localparam int FRAME = 11 * CPB;
`else
  localparam int FRAME = 10 * CPB;
`endif
  localparam logic [31:0] MARKER = 32'h0000_0FFF;
  localparam logic [7:0] EXP_BASIC [8] = '{8'hA5, 8'hC3, 8'h01, 8'h12,
                                           8'h00, 8'h00, 8'h0F, 8'hFF};
  localparam logic [7:0] EXP_LIM [12] = '{8'h11, 8'h22, 8'h33, 8'h44,
                                          8'h55, 8'h66, 8'h77, 8'h88,
                                          8'h00, 8'h00, 8'h0F, 8'hFF};

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        mem_req;
  logic [3:0]  mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mem_valid = 1'b0;
  logic        tx, busy, done;
  logic [4:0]  word_count;

  logic [31:0] mem [16];
  int lat = 1;
  int req_cnt = 0;
  int valid_cyc = 0;
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] b;
  logic       p;
  logic [3:0] nib;
  int tf, tprev, base, k, lows;

  uart_prog_streamer #(
    .CLKS_PER_BIT(CPB), .WORD_BYTES(4), .ADDR_W(4), .MAX_WORDS(2),
    .END_MARKER(MARKER), .STOP_BITS(1)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid), .tx(tx), .busy(busy), .done(done),
    .word_count(word_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: answers each mem_req after lat cycles with a one-cycle valid.
  initial begin
    int a;
    forever begin
      @(negedge clk);
      mem_valid = 1'b0;
      if (mem_req === 1'b1) begin
        req_cnt = req_cnt + 1;
        a = int'(mem_addr);
        repeat (lat) @(negedge clk);
        mem_rdata = mem[a];
        mem_valid = 1'b1;
        valid_cyc = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the middle of the stop bit.
  task automatic rx_byte(output logic [7:0] rb, output int t_fall, output logic par);
    int n;
    n = 0;
    rb = '0;
    par = 1'b0;
    t_fall = -1;
    while (tx !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("rx_start_seen", {31'b0, tx}, 32'd0);
    if (tx === 1'b0) begin
      t_fall = cyc;
      repeat (2) @(negedge clk);
      chk("rx_start_bit", {31'b0, tx}, 32'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        rb[i] = tx;
      end
`ifdef UART_PARITY_EN
      repeat (CPB) @(negedge clk);
      par = tx;
`endif
      repeat (CPB) @(negedge clk);
      chk("rx_stop_bit", {31'b0, tx}, 32'd1);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (mem_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h1357_9BDF;

    // Reset state
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_tx", {31'b0, tx}, 32'd1);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", {28'b0, mem_addr}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_word_count", {27'b0, word_count}, 32'd0);

    // Basic stream: one data word then the marker from memory
    mem[0] = 32'hA5C3_0112;
    mem[1] = MARKER;
    lat = 1;
    base = req_cnt;
    start = 1'b1;
    tprev = 0;
    for (int i = 0; i < 8; i++) begin
      rx_byte(b, tf, p);
      chk($sformatf("basic_byte%0d", i), {24'b0, b}, {24'b0, EXP_BASIC[i]});
      if (i % 4 == 0) chk($sformatf("basic_first_edge%0d", i), tf, valid_cyc + 2);
      else            chk($sformatf("basic_spacing%0d", i), tf - tprev, FRAME);
      tprev = tf;
    end
    wait_done();
    chk("basic_done", {31'b0, done}, 32'd1);
    chk("basic_busy_in_done", {31'b0, busy}, 32'd0);
    chk("basic_word_count", {27'b0, word_count}, 32'd1);
    chk("basic_req_pulses", req_cnt - base, 32'd2);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_clear", {31'b0, done}, 32'd0);
    chk("done_clear_count", {27'b0, word_count}, 32'd0);

    // Word limit with 5-cycle memory latency, no marker in memory
    mem[0] = 32'h1122_3344;
    mem[1] = 32'h5566_7788;
    mem[2] = 32'hDEAD_BEEF;
    lat = 5;
    base = req_cnt;
    chk("lim_idle_busy", {31'b0, busy}, 32'd0);
    start = 1'b1;
    wait_req();
    chk("lim_req_seen", {31'b0, mem_req}, 32'd1);
    chk("lim_busy_at_req", {31'b0, busy}, 32'd1);
    for (int i = 0; i < 12; i++) begin
      rx_byte(b, tf, p);
      chk($sformatf("lim_byte%0d", i), {24'b0, b}, {24'b0, EXP_LIM[i]});
      if (i == 0) chk("lim_first_edge", tf, valid_cyc + 2);
    end
    wait_done();
    chk("lim_done", {31'b0, done}, 32'd1);
    chk("lim_word_count", {27'b0, word_count}, 32'd2);
    chk("lim_req_pulses", req_cnt - base, 32'd2);
    start = 1'b0;
    repeat (3) @(negedge clk);

`ifdef UART_PARITY_EN
    // Even parity: 0x07 has three ones, 0x03 has two
    mem[0] = 32'h0703_0000;
    mem[1] = MARKER;
    lat = 1;
    start = 1'b1;
    rx_byte(b, tf, p);
    chk("par_byte07", {24'b0, b}, 32'h07);
    chk("par_bit07", {31'b0, p}, 32'd1);
    rx_byte(b, tf, p);
    chk("par_byte03", {24'b0, b}, 32'h03);
    chk("par_bit03", {31'b0, p}, 32'd0);
    wait_done();
    chk("par_done", {31'b0, done}, 32'd1);
    start = 1'b0;
    repeat (3) @(negedge clk);
`endif

    // Abort during data bit 3 of the second byte
    mem[0] = 32'hA5C3_0112;
    mem[1] = MARKER;
    lat = 1;
    start = 1'b1;
    rx_byte(b, tf, p);
    chk("abort_byte0", {24'b0, b}, 32'hA5);
    k = 0;
    while (tx !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("abort_frame_start", {31'b0, tx}, 32'd0);
    repeat (18) @(negedge clk);
    start = 1'b0;
    for (int i = 4; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      nib[i-4] = tx;
    end
    chk("abort_upper_bits", {28'b0, nib}, 32'hC);
`ifdef UART_PARITY_EN
    repeat (CPB) @(negedge clk);
    chk("abort_parity", {31'b0, tx}, 32'd0);
`endif
    repeat (CPB) @(negedge clk);
    chk("abort_stop_mid", {31'b0, tx}, 32'd1);
    @(negedge clk);
    chk("abort_stop_end", {31'b0, tx}, 32'd1);
    lows = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (tx === 1'b0) lows++;
    end
    chk("abort_no_more_frames", lows, 32'd0);
    chk("abort_idle_busy", {31'b0, busy}, 32'd0);
    start = 1'b1;
    wait_req();
    chk("restart_req_seen", {31'b0, mem_req}, 32'd1);
    chk("restart_addr", {28'b0, mem_addr}, 32'd0);

    // Reset for one cycle in the middle of a data bit
    k = 0;
    while (tx !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("rstmid_frame_start", {31'b0, tx}, 32'd0);
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    start = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("rstmid_tx", {31'b0, tx}, 32'd1);
    chk("rstmid_busy", {31'b0, busy}, 32'd0);
    chk("rstmid_word_count", {27'b0, word_count}, 32'd0);
    chk("rstmid_mem_req", {31'b0, mem_req}, 32'd0);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
